dht11_display: RTL
==================

# dht11_display

Downstream consumer of the DHT11 reader's 40-bit frame. On each frame strobe it:
- verifies the checksum;
- clamps the humidity and temperature integer bytes to 0..99;
- converts them to BCD with a sequential shift-add-3 engine;
- drives a 4-digit multiplexed seven-segment display (humidity on the left pair, temperature on the right pair).

It sits between the sensor reader and the board pins.

## Interface
- CLK_HZ, 125000000, system clock frequency; informational only, not used in logic.
- REFRESH_DIV, 125000, clk cycles each digit is lit (1 kHz digit rate at 125 MHz); minimum 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; single clock domain.
- frame_in  in  40  sensor frame:
  - [39:32] humidity integer, [31:24] humidity decimal;
  - [23:16] temperature integer, [15:8] temperature decimal;
  - [7:0] checksum.
- frame_valid  in  1  one-cycle strobe; frame_in is valid in the same cycle.
- busy  out  1  high while a frame is being processed; strobes are ignored while high.
- data_ok  out  1  sticky; set by the first accepted frame, cleared only by reset.
- hum_bcd  out  8  {tens, ones} of displayed humidity.
- temp_bcd  out  8  {tens, ones} of displayed temperature.
- overrange  out  1  last accepted frame had a byte above 99 that was clamped.
- err_count  out  8  checksum failures, saturating at 255.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low, one-hot.
- dp  out  1  decimal point, active-low.

## Operation
- FSM states: IDLE, CHECK, CONV, LOAD.
- IDLE:
  - on frame_valid, capture frame_in into an internal register;
  - go to CHECK; busy goes high.
- CHECK computes the checksum as (b39:32 + b31:24 + b23:16 + b15:8) mod 256 and compares it with b7:0.
  - Mismatch: err_count increments (holds at 255) and the FSM returns to IDLE. Display values, data_ok and overrange are unchanged.
  - Match: load the conversion registers with min(hum,99) and min(temp,99). Record over = (hum>99) or (temp>99). Clear the iteration counter. Go to CONV.
- CONV:
  - exactly 8 iterations, one per cycle;
  - both bytes are converted in parallel;
  - each iteration first adds 3 to any BCD nibble ≥5, then shifts the combined {bcd, bin} register left by 1;
  - after iteration 8, go to LOAD.
- LOAD:
  - hum_bcd, temp_bcd and overrange take the new values;
  - data_ok is set to 1;
  - go to IDLE.
- The decimal bytes are checked but not displayed.
- Scan:
  - a free-running counter counts 0..REFRESH_DIV-1; at wrap the digit index advances 0→1→2→3→0;
  - digit 0 = temperature ones (an=1110), digit 1 = temperature tens (1101), digit 2 = humidity ones (1011), digit 3 = humidity tens (0111);
  - dp is low only while digit 2 is lit (separator).
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- While data_ok=0, every digit shows a dash (0111111).

## Timing
- Reset values:
  - busy=0, data_ok=0, hum_bcd=0x00, temp_bcd=0x00, overrange=0, err_count=0;
  - scan counter 0, digit index 0, an=1110, seg=0111111, dp=1.
- Reset is asynchronous: asserting it in any state, including mid-CONV, forces all of the above immediately. The partial conversion is discarded.
- Strobe at edge E0 (frame captured):
  - busy is high after E0;
  - CHECK evaluates at E1;
  - CONV runs E2..E9;
  - LOAD at E10; new BCD values and data_ok are visible after E10, and busy drops in the same cycle.
- A bad frame updates err_count after E1; busy drops after E1.
- A strobe while busy=1 is ignored entirely and does not count as an error. A strobe in the cycle right after busy drops is accepted.
- seg, an and dp are registered. They change only at digit-index advances, plus a one-time update after LOAD of the first good frame.
- With REFRESH_DIV=N, each an pattern is held for exactly N cycles.
- The scan runs independently of the FSM and is never stalled.

## Test plan
- Good frame 0x3700190050 (55 %, 25 °C):
  - hum_bcd=0x55 and temp_bcd=0x25 after 10 cycles;
  - data_ok=1, overrange=0, err_count=0;
  - busy high for exactly 10 cycles.
- Bad checksum 0x3700190051 after the good frame:
  - err_count=1 after 1 cycle, busy high 1 cycle;
  - hum_bcd/temp_bcd stay 0x55/0x25.
- Overrange frame 0x7800190091 (120 %):
  - hum_bcd=0x99, temp_bcd=0x25, overrange=1;
  - a following in-range good frame clears overrange.
- Busy handling: a second strobe carrying 0x0A00140072 arrives 3 cycles after the first good frame. The second frame is ignored (final hum_bcd=0x55) and err_count is unchanged.
- Scan with REFRESH_DIV=4 after the first good frame:
  - an sequence 1110,1101,1011,0111, each held 4 cycles;
  - seg shows 5 (0010010), 2 (0100100), 5, 5;
  - dp low only in the 1011 slot;
  - before any frame, seg=0111111 in all slots.
- Reset and saturation:
  - rst low during CONV: all outputs return to reset values asynchronously, and no LOAD follows release;
  - 300 bad frames leave err_count=255.

Source files
------------

// File: rtl/dht11_display_if.sv
// dht11_display_if: frame handshake between the DHT11 reader and its consumer.
//   frame_in    [39:0] sensor frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   frame_valid        one-cycle strobe, frame_in valid in the same cycle
//   busy               consumer is processing a frame; strobes are dropped while high
// master = sensor reader side, slave = dht11_display side.
interface dht11_display_if;
  logic [39:0] frame_in;
  logic        frame_valid;
  logic        busy;

  modport master (output frame_in, output frame_valid, input busy);
  modport slave  (input frame_in, input frame_valid, output busy);
endinterface

// File: rtl/dht11_display.sv
// dht11_display: checks a DHT11 frame, clamps humidity/temperature integer bytes
// to 0..99, converts them to BCD with a shift-add-3 engine and scans them onto a
// 4-digit multiplexed seven-segment display (humidity left, temperature right).
// Ports:
//   clk, rst (async, active-low)
//   fif        frame handshake (frame_in, frame_valid in; busy out)
//   data_ok    sticky, set by the first good frame
//   hum_bcd    {tens, ones} displayed humidity
//   temp_bcd   {tens, ones} displayed temperature
//   overrange  last good frame had a clamped byte
//   err_count  checksum failures, saturating at 255
//   seg/an/dp  active-low segment {g..a}, digit enables, decimal point
//
// state  | meaning
// IDLE   | waiting for frame_valid; captures frame_in
// CHECK  | compares byte sum with checksum; loads clamped bytes or counts error
// CONV   | 8 shift-add-3 iterations on both bytes in parallel
// LOAD   | publishes BCD values, overrange and data_ok
module dht11_display #(
  parameter int CLK_HZ      = 125000000,
  parameter int REFRESH_DIV = 125000
) (
  input  logic           clk,
  input  logic           rst,
  dht11_display_if.slave fif,
  output logic           data_ok,
  output logic [7:0]     hum_bcd,
  output logic [7:0]     temp_bcd,
  output logic           overrange,
  output logic [7:0]     err_count,
  output logic [6:0]     seg,
  output logic [3:0]     an,
  output logic           dp
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_CONV  = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  if (REFRESH_DIV < 2 || CLK_HZ < 1) begin : g_param_check
    $error("dht11_display: REFRESH_DIV must be at least 2 and CLK_HZ positive");
  end

  logic [1:0]  state;
  logic [39:0] frame_q;
  logic [15:0] hum_sr, temp_sr;
  logic [2:0]  iter;
  logic        over_q;
  logic [7:0]  sum, hum_clamp, temp_clamp;

  assign sum        = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign hum_clamp  = (frame_q[39:32] > 8'd99) ? 8'd99 : frame_q[39:32];
  assign temp_clamp = (frame_q[23:16] > 8'd99) ? 8'd99 : frame_q[23:16];
  assign fif.busy   = (state != S_IDLE);

  // One double-dabble step on {bcd[15:8], bin[7:0]}. Inputs are clamped to 99,
  // so no hundreds digit is ever produced and two BCD nibbles suffice.
  function automatic logic [15:0] dd_step(input logic [15:0] sr);
    logic [15:0] t;
    t = sr;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      frame_q   <= '0;
      hum_sr    <= '0;
      temp_sr   <= '0;
      iter      <= '0;
      over_q    <= 1'b0;
      hum_bcd   <= '0;
      temp_bcd  <= '0;
      overrange <= 1'b0;
      data_ok   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fif.frame_valid) begin
            frame_q <= fif.frame_in;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (sum != frame_q[7:0]) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state <= S_IDLE;
          end else begin
            hum_sr  <= {8'd0, hum_clamp};
            temp_sr <= {8'd0, temp_clamp};
            over_q  <= (frame_q[39:32] > 8'd99) || (frame_q[23:16] > 8'd99);
            iter    <= '0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          hum_sr  <= dd_step(hum_sr);
          temp_sr <= dd_step(temp_sr);
          iter    <= iter + 3'd1;
          if (iter == 3'd7) state <= S_LOAD;
        end
        S_LOAD: begin
          hum_bcd   <= hum_sr[15:8];
          temp_bcd  <= temp_sr[15:8];
          overrange <= over_q;
          data_ok   <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  // Digit 0/1 = temperature ones/tens, digit 2/3 = humidity ones/tens.
  function automatic logic [6:0] digit_seg(input logic [1:0] idx, input logic ok,
                                           input logic [7:0] hum, input logic [7:0] temp);
    logic [3:0] d;
    case (idx)
      2'd0:    d = temp[3:0];
      2'd1:    d = temp[7:4];
      2'd2:    d = hum[3:0];
      default: d = hum[7:4];
    endcase
    return ok ? seg_code(d) : SEG_DASH;
  endfunction

  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx, digit_nxt;
  logic          first_pend;
  logic [6:0]    seg_cur, seg_nxt;

  assign digit_nxt = digit_idx + 2'd1;
  assign seg_cur   = digit_seg(digit_idx, data_ok, hum_bcd, temp_bcd);
  assign seg_nxt   = digit_seg(digit_nxt, data_ok, hum_bcd, temp_bcd);

  // Segments only move at digit advances, except once right after the first
  // good frame so the dashes are replaced without waiting for the next digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt   <= '0;
      digit_idx  <= 2'd0;
      an         <= 4'b1110;
      seg        <= SEG_DASH;
      dp         <= 1'b1;
      first_pend <= 1'b0;
    end else begin
      first_pend <= (state == S_LOAD) && !data_ok;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= digit_nxt;
        an        <= ~(4'b0001 << digit_nxt);
        seg       <= seg_nxt;
        dp        <= (digit_nxt != 2'd2);
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
        if (first_pend) seg <= seg_cur;
      end
    end
  end
endmodule
